axi_read_arbiter: RTL and testbench

- Shares the single AXI read port (AR + R channels) between two cache requesters: port 0 is the instruction cache, port 1 is the data cache.
- Sits between the two caches and the top-level m_axi_* read pins.
- Allows one outstanding burst at a time.
- Uses round-robin grant with a registered arbitration decision.
- The grant is held from AR issue through the final R beat (rlast).

---
 rtl/axi_read_arbiter.sv | 167 ++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_arbiter
// Brief    : Round-robin arbiter sharing one AXI read port (AR + R) between
//            the instruction cache (port 0) and the data cache (port 1).
//            One burst in flight at a time; the grant is held from AR issue
//            through the final R beat.
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    // requester 0 (instruction cache)
    input  logic              s0_arvalid,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [7:0]        s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    output logic              s0_arready,
    output logic              s0_rvalid,
    output logic              s0_rlast,
    output logic [DATA_W-1:0] s0_rdata,
    input  logic              s0_rready,
    // requester 1 (data cache)
    input  logic              s1_arvalid,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [7:0]        s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    output logic              s1_arready,
    output logic              s1_rvalid,
    output logic              s1_rlast,
    output logic [DATA_W-1:0] s1_rdata,
    input  logic              s1_rready,
    // shared master read port
    output logic              m_axi_arvalid,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    input  logic              m_axi_arready,
    input  logic              m_axi_rvalid,
    input  logic              m_axi_rlast,
    input  logic [DATA_W-1:0] m_axi_rdata,
    output logic              m_axi_rready,
    // status
    output logic              grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_grant;
    logic   w_grant_nxt;
    logic   r_last_grant;
    logic   w_last_grant_nxt;

    logic   w_sel_arvalid;
    logic   w_sel_rready;

    // Request/ready of whichever port currently owns the bus
    assign w_sel_arvalid = r_grant ? s1_arvalid : s0_arvalid;
    assign w_sel_rready  = r_grant ? s1_rready  : s0_rready;

    // Address payload follows the grant; it only matters while arvalid is high
    assign m_axi_araddr  = r_grant ? s1_araddr  : s0_araddr;
    assign m_axi_arlen   = r_grant ? s1_arlen   : s0_arlen;
    assign m_axi_arsize  = r_grant ? s1_arsize  : s0_arsize;
    assign m_axi_arburst = r_grant ? s1_arburst : s0_arburst;

    // Read data is broadcast; the per-port rvalid qualifies it
    assign s0_rdata = m_axi_rdata;
    assign s1_rdata = m_axi_rdata;

    assign grant = r_grant;
    assign busy  = !reset && (r_state != IDLE);

    // State, grant and round-robin history registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Next-state, arbitration decision and handshake routing
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        m_axi_arvalid    = 1'b0;
        m_axi_rready     = 1'b0;
        s0_arready       = 1'b0;
        s1_arready       = 1'b0;
        s0_rvalid        = 1'b0;
        s1_rvalid        = 1'b0;
        s0_rlast         = 1'b0;
        s1_rlast         = 1'b0;

        case (r_state)
            IDLE: begin
                // Decision is registered here; the bus is driven next cycle
                if (s0_arvalid || s1_arvalid) begin
                    if (s0_arvalid && s1_arvalid) begin
                        w_grant_nxt = ~r_last_grant;
                    end else begin
                        w_grant_nxt = s1_arvalid;
                    end
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                m_axi_arvalid = w_sel_arvalid;
                s0_arready    = !r_grant && m_axi_arready;
                s1_arready    =  r_grant && m_axi_arready;
                if (!w_sel_arvalid) begin
                    // Requester withdrew before the handshake: nothing issued
                    w_state_nxt = IDLE;
                end else if (m_axi_arready) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                m_axi_rready = w_sel_rready;
                s0_rvalid    = !r_grant && m_axi_rvalid;
                s1_rvalid    =  r_grant && m_axi_rvalid;
                s0_rlast     = !r_grant && m_axi_rlast;
                s1_rlast     =  r_grant && m_axi_rlast;
                if (m_axi_rvalid && w_sel_rready && m_axi_rlast) begin
                    w_last_grant_nxt = r_grant;
                    w_state_nxt      = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Handshake outputs are held low for as long as reset is asserted
        if (reset) begin
            m_axi_arvalid = 1'b0;
            m_axi_rready  = 1'b0;
            s0_arready    = 1'b0;
            s1_arready    = 1'b0;
            s0_rvalid     = 1'b0;
            s1_rvalid     = 1'b0;
            s0_rlast      = 1'b0;
            s1_rlast      = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_read_arbiter
// Brief    : Self-checking bench for axi_read_arbiter: table of arbitration
//            scenarios plus hand sequences, with a scoreboard of expected
//            bursts checked against the master AR and R traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_read_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int LIMIT  = 500;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } req_t;

    typedef struct {
        logic port;
        req_t r;
    } exp_t;

    typedef struct {
        logic        req0;
        logic        req1;
        logic [63:0] a0;
        logic [63:0] a1;
        logic [7:0]  len;
        logic        first;
        int          gap;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              s0_arvalid, s1_arvalid;
    logic [ADDR_W-1:0] s0_araddr, s1_araddr;
    logic [7:0]        s0_arlen, s1_arlen;
    logic [2:0]        s0_arsize, s1_arsize;
    logic [1:0]        s0_arburst, s1_arburst;
    logic              s0_arready, s1_arready;
    logic              s0_rvalid, s1_rvalid;
    logic              s0_rlast, s1_rlast;
    logic [DATA_W-1:0] s0_rdata, s1_rdata;
    logic              s0_rready, s1_rready;
    logic              m_axi_arvalid;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arready;
    logic              m_axi_rvalid;
    logic              m_axi_rlast;
    logic [DATA_W-1:0] m_axi_rdata;
    logic              m_axi_rready;
    logic              grant;
    logic              busy;

    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   stall_left = 0;
    int   b_idx = 0;
    int   last_rlast_cyc = 0;
    int   last_gap = 0;
    req_t rq0[$];
    req_t rq1[$];
    exp_t exp_q[$];
    exp_t cur;
    vec_t vec[4];

    axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arready(s0_arready),
        .s0_rvalid(s0_rvalid), .s0_rlast(s0_rlast), .s0_rdata(s0_rdata), .s0_rready(s0_rready),
        .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arready(s1_arready),
        .s1_rvalid(s1_rvalid), .s1_rlast(s1_rlast), .s1_rdata(s1_rdata), .s1_rready(s1_rready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast), .m_axi_rdata(m_axi_rdata),
        .m_axi_rready(m_axi_rready), .grant(grant), .busy(busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Free-running cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic req_t mk_req(input logic p, input logic [63:0] a, input logic [7:0] l);
        req_t r;
        r.addr  = a;
        r.len   = l;
        r.size  = p ? 3'd2 : 3'd3;
        r.burst = p ? 2'd2 : 2'd1;
        return r;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] a, input int b);
        return a ^ {8'hA5, 48'h0, 8'(b)};
    endfunction

    task automatic expect_burst(input logic p, input req_t r);
        exp_t e;
        e.port = p;
        e.r    = r;
        exp_q.push_back(e);
    endtask

    // Requester drivers: hold arvalid with the queue head until accepted
    initial begin : drivers
        logic pop0, pop1;
        s0_arvalid = 0; s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0;
        s1_arvalid = 0; s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0;
        s0_rready = 1; s1_rready = 1;
        forever begin
            @(negedge clk);
            pop0 = s0_arvalid && s0_arready;
            pop1 = s1_arvalid && s1_arready;
            @(posedge clk);
            #2;
            if (pop0 && rq0.size() > 0) void'(rq0.pop_front());
            if (pop1 && rq1.size() > 0) void'(rq1.pop_front());
            s0_arvalid = (rq0.size() > 0);
            if (rq0.size() > 0) begin
                s0_araddr = rq0[0].addr; s0_arlen = rq0[0].len;
                s0_arsize = rq0[0].size; s0_arburst = rq0[0].burst;
            end
            s1_arvalid = (rq1.size() > 0);
            if (rq1.size() > 0) begin
                s1_araddr = rq1[0].addr; s1_arlen = rq1[0].len;
                s1_arsize = rq1[0].size; s1_arburst = rq1[0].burst;
            end
        end
    end

    // Memory model on the master side plus scoreboard checks of AR and R
    initial begin : slave_monitor
        logic ar_hs, r_hs, rst_seen, post_last, prev_arv, in_r;
        logic [63:0] s_addr;
        logic [7:0]  s_len;
        logic        gv, ov, gl, ol;
        logic [63:0] gd;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = '0;
        post_last = 0; prev_arv = 0; in_r = 0; s_addr = '0; s_len = '0;
        forever begin
            @(negedge clk);
            rst_seen = reset;
            ar_hs = !reset && m_axi_arvalid && m_axi_arready;
            r_hs  = !reset && m_axi_rvalid && m_axi_rready;
            if (post_last && !reset) check("idle_after_rlast", busy, 0);
            post_last = 0;
            if (m_axi_arvalid && !prev_arv) last_gap = cyc - last_rlast_cyc;
            prev_arv = m_axi_arvalid;
            if (!reset && m_axi_arvalid && !m_axi_arready && stall_left > 0) stall_left--;
            if (ar_hs) begin
                check("ar_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("ar_grant", grant, cur.port);
                    check("ar_addr", m_axi_araddr, cur.r.addr);
                    check("ar_len", m_axi_arlen, cur.r.len);
                    check("ar_size", m_axi_arsize, cur.r.size);
                    check("ar_burst", m_axi_arburst, cur.r.burst);
                end
                s_addr = m_axi_araddr;
                s_len  = m_axi_arlen;
                b_idx  = 0;
            end
            if (r_hs) begin
                gv = cur.port ? s1_rvalid : s0_rvalid;
                ov = cur.port ? s0_rvalid : s1_rvalid;
                gl = cur.port ? s1_rlast  : s0_rlast;
                ol = cur.port ? s0_rlast  : s1_rlast;
                gd = cur.port ? s1_rdata  : s0_rdata;
                check("r_valid_owner", gv, 1);
                check("r_valid_other", ov, 0);
                check("r_last_owner", gl, (b_idx == int'(cur.r.len)));
                check("r_last_other", ol, 0);
                check("r_data", gd, beat_data(cur.r.addr, b_idx));
                if (m_axi_rlast) begin
                    last_rlast_cyc = cyc;
                    post_last = 1;
                end
                b_idx++;
            end
            @(posedge clk);
            #1;
            if (rst_seen) begin
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
                in_r = 0; b_idx = 0;
            end else if (ar_hs) begin
                m_axi_arready = 0;
                in_r = 1;
                m_axi_rvalid = 1;
                m_axi_rdata = beat_data(s_addr, 0);
                m_axi_rlast = (s_len == 8'd0);
            end else if (in_r && r_hs) begin
                if (m_axi_rlast) begin
                    in_r = 0;
                    m_axi_rvalid = 0;
                    m_axi_rlast = 0;
                    m_axi_arready = (stall_left == 0);
                end else begin
                    m_axi_rdata = beat_data(s_addr, b_idx);
                    m_axi_rlast = (b_idx == int'(s_len));
                end
            end else if (!in_r) begin
                m_axi_arready = (stall_left == 0);
            end
        end
    end

    // Reset pulse with checks of the reset-gated outputs
    task automatic do_reset(input int stall);
        @(posedge clk);
        #1;
        reset = 1;
        rq0.delete(); rq1.delete(); exp_q.delete();
        stall_left = stall;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_m_arvalid", m_axi_arvalid, 0);
        check("rst_m_rready", m_axi_rready, 0);
        check("rst_s0_arready", s0_arready, 0);
        check("rst_s1_arready", s1_arready, 0);
        check("rst_s0_rvalid", s0_rvalid, 0);
        check("rst_s1_rvalid", s1_rvalid, 0);
        @(negedge clk);
        check("rst_grant", grant, 0);
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    // Wait until every queued burst has been served, bounded
    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && rq0.size() == 0 && rq1.size() == 0 &&
                     !busy && !m_axi_rvalid) && n < LIMIT);
        check({name, "_done"}, (n < LIMIT), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int n;
        reset = 1;
        // req0 req1 a0 a1 len first gap
        vec[0] = '{1'b1, 1'b0, 64'h1000, 64'h0,    8'd7, 1'b0, 0};
        vec[1] = '{1'b0, 1'b1, 64'h0,    64'hA000, 8'd2, 1'b1, 0};
        vec[2] = '{1'b1, 1'b1, 64'h2000, 64'h8000, 8'd3, 1'b0, 2};
        vec[3] = '{1'b1, 1'b1, 64'h2040, 64'h8040, 8'd0, 1'b0, 2};

        foreach (vec[i]) begin
            do_reset(0);
            @(posedge clk);
            #1;
            if (vec[i].req0) rq0.push_back(mk_req(0, vec[i].a0, vec[i].len));
            if (vec[i].req1) rq1.push_back(mk_req(1, vec[i].a1, vec[i].len));
            if (!vec[i].first) begin
                if (vec[i].req0) expect_burst(0, mk_req(0, vec[i].a0, vec[i].len));
                if (vec[i].req1) expect_burst(1, mk_req(1, vec[i].a1, vec[i].len));
            end else begin
                if (vec[i].req1) expect_burst(1, mk_req(1, vec[i].a1, vec[i].len));
                if (vec[i].req0) expect_burst(0, mk_req(0, vec[i].a0, vec[i].len));
            end
            @(negedge clk);
            check($sformatf("row%0d_arb_cycle_arvalid", i), m_axi_arvalid, 0);
            check($sformatf("row%0d_arb_cycle_busy", i), busy, 0);
            @(negedge clk);
            check($sformatf("row%0d_arvalid", i), m_axi_arvalid, 1);
            check($sformatf("row%0d_araddr", i), m_axi_araddr, vec[i].first ? vec[i].a1 : vec[i].a0);
            check($sformatf("row%0d_arlen", i), m_axi_arlen, vec[i].len);
            check($sformatf("row%0d_grant", i), grant, vec[i].first);
            wait_done($sformatf("row%0d", i));
            if (vec[i].req0 && vec[i].req1)
                check($sformatf("row%0d_rlast_to_ar_gap", i), last_gap, vec[i].gap);
        end

        // Both ports requesting continuously: grants alternate 0,1,0,1
        do_reset(0);
        @(posedge clk);
        #1;
        rq0.push_back(mk_req(0, 64'h3000, 8'd3));
        rq0.push_back(mk_req(0, 64'h3100, 8'd3));
        rq1.push_back(mk_req(1, 64'h9000, 8'd3));
        rq1.push_back(mk_req(1, 64'h9100, 8'd3));
        expect_burst(0, mk_req(0, 64'h3000, 8'd3));
        expect_burst(1, mk_req(1, 64'h9000, 8'd3));
        expect_burst(0, mk_req(0, 64'h3100, 8'd3));
        expect_burst(1, mk_req(1, 64'h9100, 8'd3));
        wait_done("alternate");

        // Port 1 requests during port 0's data phase and must wait
        do_reset(0);
        @(posedge clk);
        #1;
        rq0.push_back(mk_req(0, 64'h4000, 8'd7));
        expect_burst(0, mk_req(0, 64'h4000, 8'd7));
        n = 0;
        do begin @(negedge clk); n++; end while (!(busy && m_axi_rvalid) && n < 50);
        check("pend_data_reached", (n < 50), 1);
        @(posedge clk);
        #1;
        rq1.push_back(mk_req(1, 64'h5000, 8'd1));
        expect_burst(1, mk_req(1, 64'h5000, 8'd1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) begin
                check("pend_s1_arready", s1_arready, 0);
                check("pend_no_second_ar", m_axi_arvalid, 0);
            end
        end while (busy && n < 50);
        check("pend_burst_end", (n < 50), 1);
        wait_done("pending");

        // Interconnect stalls AR for 5 cycles
        do_reset(5);
        @(posedge clk);
        #1;
        rq0.push_back(mk_req(0, 64'h6000, 8'd0));
        expect_burst(0, mk_req(0, 64'h6000, 8'd0));
        n = 0;
        do begin @(negedge clk); n++; end while (!m_axi_arvalid && n < 50);
        check("stall_ar_seen", (n < 50), 1);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("stall%0d_arvalid", k), m_axi_arvalid, 1);
            check($sformatf("stall%0d_araddr", k), m_axi_araddr, 64'h6000);
            check($sformatf("stall%0d_s0_arready", k), s0_arready, (k == 5));
            if (k < 5) @(negedge clk);
        end
        wait_done("stall");

        // Reset on the third beat of an 8-beat burst
        do_reset(0);
        @(posedge clk);
        #1;
        rq0.push_back(mk_req(0, 64'h7000, 8'd7));
        expect_burst(0, mk_req(0, 64'h7000, 8'd7));
        n = 0;
        do begin @(posedge clk); #3; n++; end while (b_idx != 2 && n < 100);
        check("midrst_beat3_reached", (n < 100), 1);
        reset = 1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_m_rready", m_axi_rready, 0);
        check("midrst_m_arvalid", m_axi_arvalid, 0);
        @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        check("postrst_busy", busy, 0);
        check("postrst_m_rready", m_axi_rready, 0);
        check("postrst_m_arvalid", m_axi_arvalid, 0);
        @(posedge clk);
        #1;
        rq0.push_back(mk_req(0, 64'h7100, 8'd1));
        rq1.push_back(mk_req(1, 64'h7200, 8'd1));
        expect_burst(0, mk_req(0, 64'h7100, 8'd1));
        expect_burst(1, mk_req(1, 64'h7200, 8'd1));
        wait_done("after_midrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
